fp_ms_sequencer: RTL and testbench
==================================

Name: fp_ms_sequencer

Overview:
- Upstream feeder for the floating-point unit's multicycle port (s2) in the sound-level meter datapath.
- Accepts signed 24-bit PCM samples and converts each to IEEE-754 single precision.
- Squares each sample and accumulates the square by issuing multiply and add operations to the FPU through its start/done handshake.
- After N samples, emits the mean square (accumulator / N) as a float for the RMS/dB stage.

Parameters:
- LOG2N, 10, block length exponent; N = 2**LOG2N samples per result (1..16).
- OPC_MUL, 3'd1, s2 opcode for fmul.
- OPC_ADD, 3'd2, s2 opcode for fadd.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  24  signed PCM sample
- fpu_clk_en  out  1  to s2_clk_en; constant 1
- fpu_reset  out  1  to s2_reset; equals ~reset_reset_n
- fpu_start  out  1  to s2_start; single-cycle pulse
- fpu_n  out  3  to s2_n
- fpu_dataa  out  32  to s2_dataa
- fpu_datab  out  32  to s2_datab
- fpu_done  in  1  from s2_done
- fpu_result  in  32  from s2_result
- out_valid  out  1  mean-square result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  mean square, fp32
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (async):
  - outputs: in_ready=0, fpu_start=0, fpu_n=0, fpu_dataa=0, fpu_datab=0, out_valid=0, out_data=0, busy=0.
  - internal: acc=0 (+0.0), count=0, state=IDLE.
  - in_ready rises the first cycle after reset release.
- States and transitions:
  - IDLE: in_ready=1. On handshake, register fp32(in_data) into samp and go to MUL_ISSUE.
  - MUL_ISSUE: fpu_start=1 for exactly one cycle; fpu_n=OPC_MUL; dataa=datab=samp. Go to MUL_WAIT.
  - MUL_WAIT: hold dataa/datab/n stable. On fpu_done, capture fpu_result into sq and go to ADD_ISSUE.
  - ADD_ISSUE: start pulse; fpu_n=OPC_ADD; dataa=acc; datab=sq. Go to ADD_WAIT.
  - ADD_WAIT: on fpu_done, acc<=fpu_result.
    - If count==N-1: go to OUTPUT.
    - Else: count<=count+1 and go to IDLE.
  - OUTPUT: out_valid=1, out_data=scaled acc, held stable until out_ready. On handshake: acc<=0, count<=0, out_valid<=0, go to IDLE.
- Handshake rules:
  - in_ready=0 in every state except IDLE.
  - fpu_done is ignored outside the WAIT states.
  - fpu_done may arrive any cycle >=1 after start, with no upper bound.
  - fpu_done in the same cycle as the start pulse is not possible (the FPU needs at least one cycle) and need not be handled.
- Int->float conversion (combinational, exact):
  - 0 -> 0x00000000.
  - Otherwise: sign = in_data[23]; mag = |in_data| (25-bit intermediate so -8388608 -> 2^23).
  - lz = leading-zero count of the 24-bit mag; exponent = 127 + 23 - lz.
  - Mantissa = (mag << lz)[22:0]. No rounding needed.
- Scaling by N:
  - acc exponent field E. If E==0, out_data=0x00000000.
  - Else if E<=LOG2N, flush to +0.0.
  - Else out_data = {acc[31], E-LOG2N, acc[22:0]}.
  - The sign is always 0 in practice.
- Latency per sample: 1 + 1 + tmul + 1 + tadd cycles, where t is start-to-done cycles.
- Reset mid-operation aborts the block immediately; a partial accumulation is discarded.

Decomposition:
- Package fp_seq_pkg holds:
  - state enum (IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, OUTPUT);
  - FP_ZERO=32'h0;
  - default opcode constants.
- One sub-module: int24_to_fp32 (combinational converter, LZC plus shift), instantiated once.

Test Plan:
- Conversion: feed 1, -1, 8388607, -8388608; the captured fmul operands must be 0x3F800000, 0xBF800000, 0x4AFFFFFE, 0xCB000000.
- LOG2N=2, samples 2,2,2,2, with a behavioural FPU model (3-cycle done) -> one out_valid, out_data=0x40800000 (4.0).
- LOG2N=2, samples 0,0,0,0 -> out_data=0x00000000. Exactly 8 start pulses, each 1 cycle wide.
- Backpressure: hold out_ready=0 for 20 cycles -> out_data stable, in_ready=0 throughout. After out_ready, the next block starts from acc=0 (samples 1,1,1,1 -> 0x3F800000).
- Variable FPU latency (done after 1, then 17 cycles); stray done pulses in IDLE -> results unchanged and no extra count increment.
- Assert reset_reset_n low during MUL_WAIT of sample 3 -> all outputs at reset values asynchronously. The next block of 4 samples yields the correct mean with no residue.

Source files
------------

// File: rtl/fp_ms_sequencer_pkg.sv
// Shared types and constants for the mean-square FPU sequencer.
// Holds the FSM state encoding, the fp32 zero pattern and the power-of-two scaling helper.
package fp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_ISSUE = 3'd1,
        MUL_WAIT  = 3'd2,
        ADD_ISSUE = 3'd3,
        ADD_WAIT  = 3'd4,
        OUTPUT    = 3'd5
    } state_t;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [2:0]  OPC_MUL_DEF = 3'd1;
    localparam logic [2:0]  OPC_ADD_DEF = 3'd2;

    // Divide an fp32 value by 2**shift by lowering its exponent.
    // Anything that would fall into the subnormal range is flushed to +0.0.
    function automatic logic [31:0] fp_scale_pow2(input logic [31:0] v, input logic [7:0] shift);
        logic [7:0] e;
        e = v[30:23];
        if (e <= shift) begin
            return FP_ZERO;
        end
        return {v[31], e - shift, v[22:0]};
    endfunction

endpackage

// File: rtl/fp_ms_sequencer_if.sv
// Multicycle FPU port (s2) as seen by the sequencer.
// The master drives the operation, the slave (FPU) answers with done/result.
interface fp_ms_sequencer_if;
    logic        fpu_clk_en;
    logic        fpu_reset;
    logic        fpu_start;
    logic [2:0]  fpu_n;
    logic [31:0] fpu_dataa;
    logic [31:0] fpu_datab;
    logic        fpu_done;
    logic [31:0] fpu_result;

    modport master (
        output fpu_clk_en, fpu_reset, fpu_start, fpu_n, fpu_dataa, fpu_datab,
        input  fpu_done, fpu_result
    );

    modport slave (
        input  fpu_clk_en, fpu_reset, fpu_start, fpu_n, fpu_dataa, fpu_datab,
        output fpu_done, fpu_result
    );
endinterface

// File: rtl/fp_ms_sequencer_int24_to_fp32.sv
// Exact signed 24-bit integer to IEEE-754 single conversion (combinational).
// Every 24-bit magnitude fits the 24-bit significand, so no rounding is involved.
module int24_to_fp32
    import fp_seq_pkg::*;
(
    input  logic signed [23:0] i_data,
    output logic [31:0]        o_fp
);

    logic        w_sign;
    logic [23:0] w_mag;
    logic [4:0]  w_lz;
    logic [23:0] w_norm;
    logic [7:0]  w_exp;

    // -8388608 maps to 0x800000, which is still correct read as unsigned 2**23.
    assign w_sign = i_data[23];
    assign w_mag  = w_sign ? (~$unsigned(i_data) + 24'd1) : $unsigned(i_data);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (w_mag[i]) begin
                w_lz = 5'(23 - i);
            end
        end
    end

    assign w_norm = w_mag << w_lz;
    assign w_exp  = 8'd150 - {3'b000, w_lz};
    assign o_fp   = (w_mag == 24'd0) ? FP_ZERO : {w_sign, w_exp, w_norm[22:0]};

endmodule

// File: rtl/fp_ms_sequencer.sv
// Squares PCM samples and accumulates them on the external FPU, then emits
// the block mean square (sum / 2**LOG2N) as fp32.
module fp_ms_sequencer
    import fp_seq_pkg::*;
#(
    parameter int          LOG2N   = 10,
    parameter logic [2:0]  OPC_MUL = OPC_MUL_DEF,
    parameter logic [2:0]  OPC_ADD = OPC_ADD_DEF
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [23:0] in_data,
    fp_ms_sequencer_if.master  fpu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               busy
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_armed;
    logic [LOG2N-1:0]  r_count;
    logic [31:0]       r_acc;
    logic [2:0]        r_fpu_n;
    logic [31:0]       r_dataa;
    logic [31:0]       r_datab;
    logic [31:0]       w_samp_fp;
    logic              w_last;
    logic              w_in_fire;

    int24_to_fp32 u_conv (
        .i_data (in_data),
        .o_fp   (w_samp_fp)
    );

    assign w_last    = &r_count;
    assign w_in_fire = in_valid && in_ready;

    assign fpu.fpu_clk_en = 1'b1;
    assign fpu.fpu_reset  = ~reset_reset_n;
    assign fpu.fpu_n      = r_fpu_n;
    assign fpu.fpu_dataa  = r_dataa;
    assign fpu.fpu_datab  = r_datab;

    // Issue states last exactly one cycle, so start is a single-cycle pulse by construction.
    always_comb begin
        w_next_state  = r_state;
        in_ready      = 1'b0;
        fpu.fpu_start = 1'b0;
        out_valid     = 1'b0;
        out_data      = FP_ZERO;
        busy          = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                in_ready = r_armed;
                if (w_in_fire) w_next_state = MUL_ISSUE;
            end
            MUL_ISSUE: begin
                fpu.fpu_start = 1'b1;
                w_next_state  = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (fpu.fpu_done) w_next_state = ADD_ISSUE;
            end
            ADD_ISSUE: begin
                fpu.fpu_start = 1'b1;
                w_next_state  = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (fpu.fpu_done) w_next_state = w_last ? OUTPUT : IDLE;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_data  = fp_scale_pow2(r_acc, 8'(LOG2N));
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The operand registers double as the converted sample and the captured square.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_armed <= 1'b0;
            r_count <= '0;
            r_acc   <= FP_ZERO;
            r_fpu_n <= 3'd0;
            r_dataa <= FP_ZERO;
            r_datab <= FP_ZERO;
        end else begin
            r_armed <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_fpu_n <= OPC_MUL;
                        r_dataa <= w_samp_fp;
                        r_datab <= w_samp_fp;
                    end
                end
                MUL_WAIT: begin
                    if (fpu.fpu_done) begin
                        r_fpu_n <= OPC_ADD;
                        r_dataa <= r_acc;
                        r_datab <= fpu.fpu_result;
                    end
                end
                ADD_WAIT: begin
                    if (fpu.fpu_done) begin
                        r_acc <= fpu.fpu_result;
                        if (!w_last) r_count <= r_count + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_acc   <= FP_ZERO;
                        r_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_ms_sequencer.sv
// Self-checking bench: behavioural FPU plus a real-arithmetic mean-square model
// checked every cycle, with literal expectations for the hand-computed cases.
module tb_fp_ms_sequencer;

    localparam int         LOG2N   = 2;
    localparam int         N       = 4;
    localparam logic [2:0] OPC_MUL = 3'd1;
    localparam logic [2:0] OPC_ADD = 3'd2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               busy;

    fp_ms_sequencer_if fpu_if();

    fp_ms_sequencer #(.LOG2N(LOG2N)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .fpu           (fpu_if),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          since_rel;
    int          start_cnt = 0;
    logic [31:0] mul_ops[$];
    logic [31:0] outs[$];
    int          lat_mode = 0;
    int          fixed_lat = 3;
    bit          alt_flag = 1'b0;
    bit          stray_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // fp32 <-> real helpers; round-to-nearest-even on the way down.
    function automatic logic [31:0] real_to_fp32(input real v);
        logic [63:0] d;
        logic [52:0] m;
        logic [23:0] k;
        logic [28:0] rem;
        int          e;
        if (v == 0.0) return 32'h0;
        d   = $realtobits(v);
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {1'b1, d[51:0]};
        k   = m[52:29];
        rem = m[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && k[0])) begin
            k = k + 24'd1;
            if (k == 24'd0) begin
                k = 24'h80_0000;
                e++;
            end
        end
        return {d[63], e[7:0], k[22:0]};
    endfunction

    function automatic real fp32_to_real(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:0] == 31'd0) return 0.0;
        e11 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'd0});
    endfunction

    function automatic real rnd32(input real v);
        return fp32_to_real(real_to_fp32(v));
    endfunction

    function automatic logic [31:0] mean_model(input real acc);
        if (acc == 0.0) return 32'h0;
        return real_to_fp32(acc / real'(N));
    endfunction

    function automatic int pick_lat();
        if (lat_mode == 1) begin
            alt_flag = ~alt_flag;
            return alt_flag ? 1 : 17;
        end
        if (lat_mode == 2) return int'($urandom_range(1, 8));
        return fixed_lat;
    endfunction

    task automatic chk_reset(input string tag);
        check1({tag, "_in_ready"}, in_ready, 1'b0);
        check1({tag, "_start"}, fpu_if.fpu_start, 1'b0);
        check({tag, "_n"}, 32'(fpu_if.fpu_n), 32'd0);
        check({tag, "_dataa"}, fpu_if.fpu_dataa, 32'h0);
        check({tag, "_datab"}, fpu_if.fpu_datab, 32'h0);
        check1({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_fpu_reset"}, fpu_if.fpu_reset, 1'b1);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rel <= 0;
        else        since_rel <= since_rel + 1;
    end

    // Behavioural FPU: answers each start after a chosen latency, optionally
    // throwing stray done pulses while the sequencer is idle.
    initial begin
        bit          pend = 1'b0;
        int          cnt = 0;
        logic [31:0] res = 32'h0;
        real         a, b;
        fpu_if.fpu_done   = 1'b0;
        fpu_if.fpu_result = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                fpu_if.fpu_done   = 1'b0;
                fpu_if.fpu_result = 32'h0;
            end else begin
                fpu_if.fpu_done = 1'b0;
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        fpu_if.fpu_done   = 1'b1;
                        fpu_if.fpu_result = res;
                        pend = 1'b0;
                    end
                end else if (fpu_if.fpu_start) begin
                    a = fp32_to_real(fpu_if.fpu_dataa);
                    b = fp32_to_real(fpu_if.fpu_datab);
                    if (fpu_if.fpu_n == OPC_MUL)      res = real_to_fp32(a * b);
                    else if (fpu_if.fpu_n == OPC_ADD) res = real_to_fp32(a + b);
                    else                              res = 32'hDEAD_BEEF;
                    pend = 1'b1;
                    cnt  = pick_lat();
                end else if (stray_en && in_ready && $urandom_range(0, 2) == 0) begin
                    fpu_if.fpu_done   = 1'b1;
                    fpu_if.fpu_result = $urandom;
                end
            end
        end
    end

    // Compare process: sum-of-squares model driven by accepted samples.
    initial begin
        int          phase = 0;
        int          cur = 0;
        int          cnt_m = 0;
        real         acc_m = 0.0;
        real         sq_m = 0.0;
        logic [31:0] exp_op;
        logic [2:0]  hold_n = 3'd0;
        logic [31:0] hold_a = 32'h0;
        logic [31:0] hold_b = 32'h0;
        logic        prev_start = 1'b0;
        logic        prev_ov = 1'b0;
        logic        prev_or = 1'b0;
        logic [31:0] prev_od = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_reset("reset");
                phase = 0; cnt_m = 0; acc_m = 0.0;
                prev_start = 1'b0; prev_ov = 1'b0; prev_or = 1'b0;
            end else begin
                check1("clk_en", fpu_if.fpu_clk_en, 1'b1);
                check1("fpu_reset", fpu_if.fpu_reset, 1'b0);
                if (since_rel == 0) begin
                    check1("ready_first_cycle", in_ready, 1'b0);
                    check1("busy_first_cycle", busy, 1'b0);
                end else begin
                    check1("busy_vs_ready", busy, !in_ready);
                end
                if (fpu_if.fpu_start) begin
                    start_cnt++;
                    check1("start_width", prev_start, 1'b0);
                    if (phase == 1) begin
                        exp_op = real_to_fp32(real'(cur));
                        check("mul_n", 32'(fpu_if.fpu_n), 32'(OPC_MUL));
                        check("mul_a", fpu_if.fpu_dataa, exp_op);
                        check("mul_b", fpu_if.fpu_datab, exp_op);
                        mul_ops.push_back(fpu_if.fpu_dataa);
                        sq_m  = rnd32(real'(cur) * real'(cur));
                        phase = 2;
                    end else if (phase == 2) begin
                        check("add_n", 32'(fpu_if.fpu_n), 32'(OPC_ADD));
                        check("add_acc", fpu_if.fpu_dataa, real_to_fp32(acc_m));
                        check("add_sq", fpu_if.fpu_datab, real_to_fp32(sq_m));
                        acc_m = rnd32(acc_m + sq_m);
                        cnt_m++;
                        phase = (cnt_m == N) ? 3 : 0;
                    end else begin
                        check1("unexpected_start", 1'b1, 1'b0);
                    end
                    hold_n = fpu_if.fpu_n;
                    hold_a = fpu_if.fpu_dataa;
                    hold_b = fpu_if.fpu_datab;
                end else if (busy && !out_valid) begin
                    check("hold_n", 32'(fpu_if.fpu_n), 32'(hold_n));
                    check("hold_a", fpu_if.fpu_dataa, hold_a);
                    check("hold_b", fpu_if.fpu_datab, hold_b);
                end
                if (out_valid) begin
                    check1("out_valid_expected", phase == 3, 1'b1);
                    check("out_data", out_data, mean_model(acc_m));
                    check1("ready_in_output", in_ready, 1'b0);
                    if (prev_ov && !prev_or) check("out_hold", out_data, prev_od);
                    if (out_ready) begin
                        outs.push_back(out_data);
                        phase = 0; cnt_m = 0; acc_m = 0.0;
                    end
                end
                if (phase == 0 && in_valid && in_ready) begin
                    cur   = int'(in_data);
                    phase = 1;
                end
                prev_start = fpu_if.fpu_start;
                prev_ov    = out_valid;
                prev_or    = out_ready;
                prev_od    = out_data;
            end
        end
    end

    task automatic send(input logic signed [23:0] x);
        bit done = 1'b0;
        @(posedge clk); #1;
        in_data  = x;
        in_valid = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check1("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic recv(input int dly, output logic [31:0] d);
        bit done = 1'b0;
        d = 32'h0;
        @(posedge clk); #1;
        repeat (dly) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (out_valid) begin
                d = out_data;
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        out_ready = 1'b0;
        if (!done) check1("recv_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_block(input int v0, input int v1, input int v2, input int v3);
        send(24'(v0)); send(24'(v1)); send(24'(v2)); send(24'(v3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        int          snap;
        bit          seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) check1("in_ready_held_low", in_ready, 1'b0);
        @(negedge clk) check1("in_ready_rises", in_ready, 1'b1);

        // Conversion of the extreme and unit samples.
        mul_ops.delete();
        send_block(1, -1, 8388607, -8388608);
        recv(0, d);
        check("conv_count", 32'(mul_ops.size()), 32'd4);
        if (mul_ops.size() == 4) begin
            check("conv_p1", mul_ops[0], 32'h3F80_0000);
            check("conv_m1", mul_ops[1], 32'hBF80_0000);
            check("conv_max", mul_ops[2], 32'h4AFF_FFFE);
            check("conv_min", mul_ops[3], 32'hCB00_0000);
        end

        send_block(2, 2, 2, 2);
        recv(0, d);
        check("mean_twos", d, 32'h4080_0000);

        snap = start_cnt;
        send_block(0, 0, 0, 0);
        recv(0, d);
        check("mean_zeros", d, 32'h0);
        check("zero_block_starts", 32'(start_cnt - snap), 32'd8);

        // Output backpressure with an offered sample that must not be taken.
        send_block(3, 3, 3, 3);
        seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check1("bp_out_valid_seen", seen, 1'b1);
        held = out_data;
        @(posedge clk); #1;
        in_data  = 24'sd7;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check1("bp_in_ready", in_ready, 1'b0);
            check1("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, held);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        recv(0, d);
        check("mean_threes", d, 32'h4110_0000);
        send_block(1, 1, 1, 1);
        recv(0, d);
        check("mean_ones_after_bp", d, 32'h3F80_0000);

        // Alternating 1/17-cycle FPU latency with stray done pulses in IDLE.
        lat_mode = 1;
        stray_en = 1'b1;
        send_block(4, 4, 4, 4);
        recv(0, d);
        check("mean_fours_varlat", d, 32'h4180_0000);
        send_block(-1000, 2047, -2048, 37);
        recv(2, d);

        // Reset during MUL_WAIT of the third sample.
        lat_mode  = 0;
        fixed_lat = 10;
        send(24'sd1);
        send(24'sd2);
        send(24'sd3);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 chk_reset("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_block(5, 5, 5, 5);
        recv(0, d);
        check("mean_fives_after_reset", d, 32'h41C8_0000);

        // Randomised blocks, latencies, gaps and consumer delays.
        lat_mode = 2;
        for (int b = 0; b < 6; b++) begin
            for (int s = 0; s < N; s++) begin
                int v;
                v = int'($urandom_range(0, 4095)) - 2048;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(24'(v));
            end
            recv(int'($urandom_range(0, 6)), d);
        end

        stray_en = 1'b0;
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
